plot_scheduler: RTL and testbench
=================================

PLOT_SCHEDULER -- requirements
Module: plot_scheduler

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, meaning the update queue depth (power of two, 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port upd_valid, input, 1 bit: a cell update is offered.
REQ-005 The module SHALL have port upd_ready, output, 1 bit: the queue can accept an update.
REQ-006 The module SHALL have ports upd_x and upd_y, input, 4 bits each: the grid cell of the update.
REQ-007 The module SHALL have port upd_colour, input, 3 bits: the colour of the update.
REQ-008 The module SHALL have port clear, input, 1 bit: a one-cycle pulse requesting a full-board fill.
REQ-009 The module SHALL have port clear_colour, input, 3 bits: the fill colour, sampled with clear.
REQ-010 The module SHALL have port busy, output, 1 bit: work is queued or in flight.
REQ-011 The module SHALL have port game_plot, output, 1 bit: plot request to the cell plotter.
REQ-012 The module SHALL have ports game_x and game_y, output, 4 bits each: the requested cell.
REQ-013 The module SHALL have port game_colour, output, 3 bits: the requested colour.
REQ-014 The module SHALL have port waitrequest, input, 1 bit: the plotter is busy.

Function
REQ-015 A downstream transfer SHALL occur on a rising clk edge where game_plot=1 and waitrequest=0.
REQ-016 While game_plot=1 and no transfer has occurred, game_x, game_y and game_colour SHALL be held stable.
REQ-017 game_plot, game_x, game_y and game_colour SHALL be registered outputs. They SHALL change only:
- on a transfer edge, or
- on an edge where game_plot=0.
REQ-018 After a transfer edge, the next cycle SHALL present either:
- the next item, or
- game_plot=0.
Re-presenting the item just transferred SHALL NOT occur.
REQ-019 An upstream push SHALL occur on an edge with upd_valid=1 and upd_ready=1.
REQ-020 upd_ready SHALL equal not-full and SHALL NOT depend combinationally on upd_valid or waitrequest.
REQ-021 Queue order SHALL be FIFO; a push to an empty queue while IDLE SHALL raise game_plot on the next edge, giving 1-cycle latency.
REQ-022 The state machine SHALL have the states IDLE, CLEAR and ISSUE.
- IDLE -> CLEAR when a clear is pending.
- Otherwise IDLE -> ISSUE when the queue is non-empty.
- ISSUE -> IDLE after a transfer, when there is no further work.
REQ-023 On a clear pulse, clear_colour SHALL be latched, and a pending-clear flag SHALL be set and held until the sweep starts.
REQ-024 The CLEAR sweep SHALL issue 256 requests, with cell index 0..255, x = index[3:0] and y = index[7:4]. It SHALL leave CLEAR after the transfer of index 255.
REQ-025 A clear SHALL take priority over queued updates.
- If it arrives during ISSUE, the in-flight request completes first.
- The sweep then begins before the next queued item.
REQ-026 A clear arriving during CLEAR SHALL restart the sweep at index 0 with the new colour.
- The restart takes effect after the in-flight request transfers.
REQ-027 Updates SHALL be accepted during CLEAR when not full, and SHALL be issued after the sweep completes.
REQ-028 busy SHALL be 1 whenever any of the following holds:
- state is not IDLE;
- the queue is non-empty;
- a clear is pending.
REQ-029 A clear simultaneous with a push SHALL accept both, with the sweep issued first.

Reset
REQ-030 While rst_n=0, the following SHALL hold:
- state = IDLE, queue empty, pending-clear = 0, sweep index = 0;
- game_plot = 0, game_x = 0, game_y = 0, game_colour = 0;
- upd_ready = 1, busy = 0.
REQ-031 A reset asserted mid-operation SHALL abandon all queued and in-flight work without waiting for waitrequest.

Structure
REQ-032 A shared package game_pkg SHALL hold:
- typedef cell_coord_t (4 bits);
- typedef colour_t (3 bits);
- constant GRID_CELLS = 256;
- the scheduler state enum.
REQ-033 The queue SHALL be a separate sub-module named plot_fifo, with a valid/ready push side and an empty/pop side.

Verification
REQ-034 Push (3,5,colour 2) with waitrequest held at 0: game_plot is high for exactly 1 cycle with x=3, y=5, colour=2; busy returns to 0.
REQ-035 Push 4 updates with waitrequest=1 for 36 cycles after each transfer:
- upd_ready drops after the 4th push;
- the outputs stay stable throughout each wait;
- transfers occur in push order.
REQ-036 Pulse clear with colour 7 while idle: exactly 256 transfers, at (0,0),(1,0)..(15,15), all with colour 7.
REQ-037 Pulse clear with colour 1 during an update wait: the update transfers unchanged, then the 256-cell sweep runs, then the remaining queue drains.
REQ-038 Pulse clear with colour 4 at sweep index 100: the in-flight cell completes, then the sweep restarts at (0,0) with colour 4.
REQ-039 Deassert rst_n mid-sweep with waitrequest=1: all outputs reach their reset values immediately; no further requests are issued after release.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared cell, colour and scheduler state types for the plot path
// Contents: cell_coord_t, colour_t, plot_cmd_t, GRID_CELLS, sched_state_t
package game_pkg;

    typedef logic [3:0] cell_coord_t;
    typedef logic [2:0] colour_t;

    localparam int GRID_CELLS = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ISSUE = 2'd2
    } sched_state_t;

    // One queued cell update as stored in the update queue.
    typedef struct packed {
        cell_coord_t x;
        cell_coord_t y;
        colour_t     colour;
    } plot_cmd_t;

endpackage

// File: rtl/plot_fifo.sv
// rtl/plot_fifo.sv - update queue with valid/ready push side and empty/pop side
// Ports: clk, rst_n (async, active-low)
//        push_valid/push_ready/push_data : push side, push_ready = not full
//        pop, empty, head_data           : pop side, head_data is the oldest entry
//        next_data, count                : entry behind the head and occupancy
module plot_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic                       empty,
    output logic [WIDTH-1:0]           head_data,
    output logic [WIDTH-1:0]           next_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign push_ready = (count != CW'(DEPTH));
    assign empty      = (count == '0);
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop && !empty;
    assign head_data  = mem[rd_ptr];
    // Lets the consumer move straight onto the following entry on the same
    // edge that retires the head.
    assign next_data  = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// rtl/plot_scheduler.sv - schedules cell updates and full-board clears to the cell plotter
// Ports: clk, rst_n (async, active-low)
//        upd_valid/upd_ready/upd_x/upd_y/upd_colour : update push side
//        clear, clear_colour                         : full-board fill request
//        busy                                        : work queued, pending or in flight
//        game_plot/game_x/game_y/game_colour         : registered plot request
//        waitrequest                                 : plotter stall
module plot_scheduler
    import game_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  cell_coord_t upd_x,
    input  cell_coord_t upd_y,
    input  colour_t     upd_colour,
    input  logic        clear,
    input  colour_t     clear_colour,
    output logic        busy,
    output logic        game_plot,
    output cell_coord_t game_x,
    output cell_coord_t game_y,
    output colour_t     game_colour,
    input  logic        waitrequest
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sched_state_t   state;
    logic           pend_clear;
    colour_t        pend_colour;
    logic [7:0]     sweep_idx;
    logic [7:0]     sweep_next;
    logic           xfer;
    logic           fifo_pop;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    plot_cmd_t      push_cmd;
    plot_cmd_t      head_cmd;
    plot_cmd_t      next_cmd;

    assign push_cmd   = '{x: upd_x, y: upd_y, colour: upd_colour};
    assign xfer       = game_plot && !waitrequest;
    // The presented update stays in the queue until it transfers, so the
    // occupancy seen upstream includes the in-flight item.
    assign fifo_pop   = xfer && (state == ST_ISSUE);
    assign sweep_next = sweep_idx + 8'd1;
    assign busy       = (state != ST_IDLE) || !fifo_empty || pend_clear;

    plot_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(plot_cmd_t))
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (upd_valid),
        .push_ready (upd_ready),
        .push_data  (push_cmd),
        .pop        (fifo_pop),
        .empty      (fifo_empty),
        .head_data  (head_cmd),
        .next_data  (next_cmd),
        .count      (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pend_clear  <= 1'b0;
            pend_colour <= '0;
            sweep_idx   <= '0;
            game_plot   <= 1'b0;
            game_x      <= '0;
            game_y      <= '0;
            game_colour <= '0;
        end else begin
            if (clear) begin
                pend_clear  <= 1'b1;
                pend_colour <= clear_colour;
            end

            // The sweep start branch appears in three states; a clear landing
            // on the same edge as the start stays pending and restarts later.
            case (state)
                ST_IDLE: begin
                    if (pend_clear) begin
                        state       <= ST_CLEAR;
                        sweep_idx   <= '0;
                        game_plot   <= 1'b1;
                        game_x      <= '0;
                        game_y      <= '0;
                        game_colour <= pend_colour;
                        if (!clear) pend_clear <= 1'b0;
                    end else if (!fifo_empty) begin
                        state       <= ST_ISSUE;
                        game_plot   <= 1'b1;
                        game_x      <= head_cmd.x;
                        game_y      <= head_cmd.y;
                        game_colour <= head_cmd.colour;
                    end
                end

                ST_ISSUE: begin
                    if (xfer) begin
                        if (pend_clear) begin
                            state       <= ST_CLEAR;
                            sweep_idx   <= '0;
                            game_x      <= '0;
                            game_y      <= '0;
                            game_colour <= pend_colour;
                            if (!clear) pend_clear <= 1'b0;
                        end else if (fifo_count > CW'(1)) begin
                            game_x      <= next_cmd.x;
                            game_y      <= next_cmd.y;
                            game_colour <= next_cmd.colour;
                        end else begin
                            state     <= ST_IDLE;
                            game_plot <= 1'b0;
                        end
                    end
                end

                ST_CLEAR: begin
                    if (xfer) begin
                        if (pend_clear) begin
                            sweep_idx   <= '0;
                            game_x      <= '0;
                            game_y      <= '0;
                            game_colour <= pend_colour;
                            if (!clear) pend_clear <= 1'b0;
                        end else if (sweep_idx == 8'(GRID_CELLS - 1)) begin
                            state     <= ST_IDLE;
                            game_plot <= 1'b0;
                        end else begin
                            sweep_idx <= sweep_next;
                            game_x    <= sweep_next[3:0];
                            game_y    <= sweep_next[7:4];
                        end
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    game_plot <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plot_scheduler.sv
// tb/tb_plot_scheduler.sv - directed self-checking bench for plot_scheduler
module tb_plot_scheduler;
    import game_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [3:0]  upd_x = '0;
    logic [3:0]  upd_y = '0;
    logic [2:0]  upd_colour = '0;
    logic        clear = 1'b0;
    logic [2:0]  clear_colour = '0;
    logic        busy;
    logic        game_plot;
    logic [3:0]  game_x;
    logic [3:0]  game_y;
    logic [2:0]  game_colour;
    logic        waitrequest;

    logic        wr_hold = 1'b0;
    logic        wr_busy = 1'b0;
    bit          wr_auto = 1'b0;
    int          wr_cnt = 0;
    bit          xfer_flag = 1'b0;

    int          xq[$];
    int          eq[$];
    int          plot_cycles = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_out = '0;

    int          n_checks = 0;
    int          n_pass = 0;

    assign waitrequest = wr_hold | wr_busy;

    always #5 clk = ~clk;

    plot_scheduler #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_x        (upd_x),
        .upd_y        (upd_y),
        .upd_colour   (upd_colour),
        .clear        (clear),
        .clear_colour (clear_colour),
        .busy         (busy),
        .game_plot    (game_plot),
        .game_x       (game_x),
        .game_y       (game_y),
        .game_colour  (game_colour),
        .waitrequest  (waitrequest)
    );

    function automatic int enc(input int x, input int y, input int c);
        return (x << 7) | (y << 3) | c;
    endfunction

    // Transfer log and hold-stability monitor; reads pre-edge values.
    always @(posedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && ({game_plot, game_x, game_y, game_colour} != prev_out))
                stab_err++;
            if (game_plot) plot_cycles++;
            if (game_plot && !waitrequest) begin
                xq.push_back(enc(int'(game_x), int'(game_y), int'(game_colour)));
                xfer_flag = 1'b1;
            end
            prev_stall = game_plot && waitrequest;
            prev_out   = {game_plot, game_x, game_y, game_colour};
        end
    end

    // Automatic plotter stall: 36 cycles of waitrequest after each transfer.
    always @(negedge clk) begin
        if (xfer_flag) begin
            xfer_flag = 1'b0;
            if (wr_auto) wr_cnt = 36;
        end
        wr_busy = (wr_cnt > 0);
        if (wr_cnt > 0) wr_cnt--;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_xfers(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (xq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (xq.size() < n) begin
            n_checks++;
            $display("FAIL %s timeout: %0d transfers, required %0d", name, xq.size(), n);
        end
    endtask

    task automatic check_seq(input string name, input int start);
        int bad;
        bad = -1;
        chk({name, "_count"}, xq.size() - start, eq.size());
        for (int i = 0; i < eq.size(); i++) begin
            if (start + i < xq.size() && xq[start + i] != eq[i]) begin
                bad = i;
                break;
            end
        end
        n_checks++;
        if (bad < 0) n_pass++;
        else $display("FAIL %s item %0d: got %03h required %03h", name, bad, xq[start + bad], eq[bad]);
    endtask

    task automatic push_upd(input int x, input int y, input int c);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_x      = 4'(x);
        upd_y      = 4'(y);
        upd_colour = 3'(c);
    endtask

    task automatic pulse_clear(input int c);
        @(negedge clk);
        clear        = 1'b1;
        clear_colour = 3'(c);
        @(negedge clk);
        clear        = 1'b0;
    endtask

    task automatic add_sweep(input int last, input int c);
        for (int i = 0; i <= last; i++) eq.push_back(enc(i & 15, i >> 4, c));
    endtask

    typedef struct {
        int x;
        int y;
        int c;
        int exp_x;
        int exp_y;
        int exp_c;
    } vec_t;

    vec_t vt[3];

    initial begin
        int start;
        int pc0;
        int st0;
        bit found;

        vt[0] = '{3, 5, 2, 3, 5, 2};
        vt[1] = '{15, 15, 7, 15, 15, 7};
        vt[2] = '{0, 0, 0, 0, 0, 0};

        // Reset state
        tick(2);
        chk("rst_game_plot", game_plot, 0);
        chk("rst_game_x", game_x, 0);
        chk("rst_game_y", game_y, 0);
        chk("rst_game_colour", game_colour, 0);
        chk("rst_upd_ready", upd_ready, 1);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

        // Single updates with no stall: one-cycle latency, one plot cycle
        for (int i = 0; i < 3; i++) begin
            start = xq.size();
            pc0   = plot_cycles;
            push_upd(vt[i].x, vt[i].y, vt[i].c);
            @(negedge clk);
            upd_valid = 1'b0;
            chk("vec_busy_queued", busy, 1);
            chk("vec_plot_before", game_plot, 0);
            @(negedge clk);
            chk("vec_plot_latency", game_plot, 1);
            chk("vec_game_x", game_x, vt[i].exp_x);
            chk("vec_game_y", game_y, vt[i].exp_y);
            chk("vec_game_colour", game_colour, vt[i].exp_c);
            @(negedge clk);
            chk("vec_plot_after", game_plot, 0);
            chk("vec_busy_after", busy, 0);
            chk("vec_xfer_count", xq.size() - start, 1);
            chk("vec_plot_cycles", plot_cycles - pc0, 1);
            if (xq.size() > start)
                chk("vec_xfer_cell", xq[start], enc(vt[i].exp_x, vt[i].exp_y, vt[i].exp_c));
        end

        // Four updates against a slow plotter
        start = xq.size();
        st0   = stab_err;
        wr_hold = 1'b1;
        push_upd(1, 2, 3);
        push_upd(4, 5, 6);
        push_upd(7, 8, 1);
        chk("q4_ready_before_4th", upd_ready, 1);
        push_upd(10, 11, 5);
        @(negedge clk);
        upd_valid = 1'b0;
        chk("q4_ready_full", upd_ready, 0);
        wr_auto = 1'b1;
        wr_hold = 1'b0;
        wait_xfers("q4", start + 4, 250);
        eq.delete();
        eq.push_back(enc(1, 2, 3));
        eq.push_back(enc(4, 5, 6));
        eq.push_back(enc(7, 8, 1));
        eq.push_back(enc(10, 11, 5));
        check_seq("q4_order", start);
        chk("q4_stable", stab_err - st0, 0);
        tick(40);
        wr_auto = 1'b0;
        chk("q4_busy_done", busy, 0);
        chk("q4_ready_done", upd_ready, 1);

        // Clear while idle
        start = xq.size();
        pulse_clear(7);
        wait_xfers("clr7", start + 256, 400);
        tick(3);
        eq.delete();
        add_sweep(255, 7);
        check_seq("clr7_sweep", start);
        chk("clr7_busy_done", busy, 0);

        // Clear arriving while an update is stalled
        start = xq.size();
        st0   = stab_err;
        wr_hold = 1'b1;
        push_upd(2, 3, 4);
        push_upd(5, 6, 5);
        @(negedge clk);
        upd_valid = 1'b0;
        tick(3);
        pulse_clear(1);
        tick(3);
        chk("clrupd_busy_stalled", busy, 1);
        wr_hold = 1'b0;
        wait_xfers("clrupd", start + 258, 600);
        tick(3);
        eq.delete();
        eq.push_back(enc(2, 3, 4));
        add_sweep(255, 1);
        eq.push_back(enc(5, 6, 5));
        check_seq("clrupd_order", start);
        chk("clrupd_stable", stab_err - st0, 0);
        chk("clrupd_busy_done", busy, 0);

        // Clear restart at sweep index 100
        start = xq.size();
        pulse_clear(5);
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge clk);
            if (game_plot && game_x == 4'd4 && game_y == 4'd6) begin
                wr_hold = 1'b1;
                found   = 1'b1;
            end
        end
        chk("restart_reached_idx100", int'(found), 1);
        pulse_clear(4);
        tick(2);
        wr_hold = 1'b0;
        wait_xfers("restart", start + 357, 700);
        tick(3);
        eq.delete();
        add_sweep(100, 5);
        add_sweep(255, 4);
        check_seq("restart_order", start);
        chk("restart_busy_done", busy, 0);

        // Reset mid-sweep with the plotter stalled
        pulse_clear(3);
        tick(20);
        wr_hold = 1'b1;
        push_upd(9, 9, 2);
        @(negedge clk);
        upd_valid = 1'b0;
        tick(2);
        chk("midrst_plot_before", game_plot, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_game_plot", game_plot, 0);
        chk("midrst_game_x", game_x, 0);
        chk("midrst_game_y", game_y, 0);
        chk("midrst_game_colour", game_colour, 0);
        chk("midrst_upd_ready", upd_ready, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        wr_hold = 1'b0;
        start   = xq.size();
        tick(300);
        chk("midrst_no_xfers", xq.size() - start, 0);
        chk("midrst_plot_idle", game_plot, 0);
        chk("midrst_busy_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
